// File: rtl/fsm4_seq_detector.sv
// fsm4_seq_detector: serial "1011" sequence detector (Moore machine).
// dout is high for one cycle while the FSM sits in the hit state S4.
// OVERLAP=1 reuses the trailing "1" of a hit as a new prefix; OVERLAP=0 restarts the search.
// Optional feature macro: FSM4_MATCH_CNT_EN adds an 8-bit saturating hit counter (match_cnt).
module fsm4_seq_detector #(
    parameter int OVERLAP = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       seq,
`ifdef FSM4_MATCH_CNT_EN
    output logic [7:0] match_cnt,
`endif
    output logic       dout
);

    typedef enum logic [2:0] {
        S0 = 3'b000,  // nothing matched
        S1 = 3'b001,  // "1"
        S2 = 3'b010,  // "10"
        S3 = 3'b011,  // "101"
        S4 = 3'b100   // "1011" hit
    } state_t;

    state_t r_state;
    state_t w_next;

    // State register; synchronous reset has priority over the data bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S0;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; any code outside S0..S4 falls back to S0.
    always_comb begin
        w_next = S0;
        case (r_state)
            S0: w_next = seq ? S1 : S0;
            S1: w_next = seq ? S1 : S2;
            S2: w_next = seq ? S3 : S0;
            S3: w_next = seq ? S4 : S2;
            S4: begin
                if (seq) begin
                    w_next = S1;
                end else begin
                    w_next = (OVERLAP != 0) ? S2 : S0;
                end
            end
            default: w_next = S0;
        endcase
    end

    // Moore output decode from the registered state.
    always_comb begin
        dout = 1'b0;
        if (r_state == S4) begin
            dout = 1'b1;
        end
    end

`ifdef FSM4_MATCH_CNT_EN
    logic [7:0] r_match_cnt;

    // Hit counter: bumps on the edge entering S4 so it moves together with dout; saturates at 255.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_match_cnt <= '0;
        end else if ((w_next == S4) && (r_match_cnt != 8'hFF)) begin
            r_match_cnt <= r_match_cnt + 8'd1;
        end
    end

    assign match_cnt = r_match_cnt;
`endif

endmodule

// File: tb/tb_fsm4_seq_detector.sv
// tb_fsm4_seq_detector: checks the "1011" detector (both OVERLAP settings) against a
// sliding-window model of the bit stream, plus directed literal expectations.
// Optional feature macro: FSM4_MATCH_CNT_EN also checks the hit counters.
module tb_fsm4_seq_detector;

    logic clk = 1'b0;
    logic i_rst = 1'b0;
    logic i_seq = 1'b0;
    logic dout1;
    logic dout0;
`ifdef FSM4_MATCH_CNT_EN
    logic [7:0] cnt1;
    logic [7:0] cnt0;
`endif

    int unsigned n_check = 0;
    int unsigned n_pass  = 0;

    always #5 clk = ~clk;

    fsm4_seq_detector #(.OVERLAP(1)) dut_ol1 (
        .clk       (clk),
        .rst       (i_rst),
        .seq       (i_seq),
`ifdef FSM4_MATCH_CNT_EN
        .match_cnt (cnt1),
`endif
        .dout      (dout1)
    );

    fsm4_seq_detector #(.OVERLAP(0)) dut_ol0 (
        .clk       (clk),
        .rst       (i_rst),
        .seq       (i_seq),
`ifdef FSM4_MATCH_CNT_EN
        .match_cnt (cnt0),
`endif
        .dout      (dout0)
    );

    // Reference model: last four bits since reset, and how many bits are usable in the window.
    // Overlapping mode may use any bit since reset; non-overlapping mode only bits since the last hit.
    logic        m_valid = 1'b0;
    logic [3:0]  m_hist;
    int unsigned m_n1;
    int unsigned m_n0;
    logic        e1;
    logic        e0;
    int unsigned c1;
    int unsigned c0;

    logic [3:0] w_hist;
    logic       w_hit1;
    logic       w_hit0;
    assign w_hist = {m_hist[2:0], i_seq};
    assign w_hit1 = (m_n1 >= 3) && (w_hist == 4'b1011);
    assign w_hit0 = (m_n0 >= 3) && (w_hist == 4'b1011);

    // Model update on each rising edge.
    always @(posedge clk) begin
        if (i_rst) begin
            m_valid <= 1'b1;
            m_hist  <= 4'b0000;
            m_n1    <= 0;
            m_n0    <= 0;
            e1      <= 1'b0;
            e0      <= 1'b0;
            c1      <= 0;
            c0      <= 0;
        end else begin
            m_hist <= w_hist;
            e1     <= w_hit1;
            e0     <= w_hit0;
            if (m_n1 < 3) m_n1 <= m_n1 + 1;
            if (w_hit0) m_n0 <= 0;
            else if (m_n0 < 3) m_n0 <= m_n0 + 1;
            if (w_hit1 && c1 < 255) c1 <= c1 + 1;
            if (w_hit0 && c0 < 255) c0 <= c0 + 1;
        end
    end

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_check++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle after the first reset, DUT outputs against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            check("model_dout_ol1", int'(dout1 === 1'b1), int'(e1));
            check("model_dout_ol0", int'(dout0 === 1'b1), int'(e0));
`ifdef FSM4_MATCH_CNT_EN
            check("model_cnt_ol1", int'(cnt1), c1);
            check("model_cnt_ol0", int'(cnt0), c0);
`endif
        end
    end

    // Drive one edge worth of inputs; returns 1 time unit after that edge.
    task automatic step(input logic r, input logic s);
        i_rst = r;
        i_seq = s;
        @(posedge clk);
        #1;
    endtask

    task automatic bits4(input logic [3:0] b);
        for (int i = 3; i >= 0; i--) step(1'b0, b[i]);
    endtask

    initial begin
        logic [6:0] ovl;
        logic [4:0] miss_a;
        #2;

        // Reset held two edges with seq=1.
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        check("reset_dout_ol1", int'(dout1), 0);
        check("reset_dout_ol0", int'(dout0), 0);
        step(1'b0, 1'b1);
        check("after_reset_s1", int'(dout1), 0);

        // Basic hit.
        step(1'b1, 1'b0);
        bits4(4'b1011);
        check("basic_hit_ol1", int'(dout1), 1);
        check("basic_hit_ol0", int'(dout0), 1);
        step(1'b0, 1'b0);
        check("basic_clear_ol1", int'(dout1), 0);

        // Overlap stream 1011011.
        step(1'b1, 1'b0);
        ovl = 7'b1011011;
        for (int i = 6; i >= 0; i--) begin
            step(1'b0, ovl[i]);
            if (i == 3) begin
                check("ovl_bit4_ol1", int'(dout1), 1);
                check("ovl_bit4_ol0", int'(dout0), 1);
            end
        end
        check("ovl_bit7_ol1", int'(dout1), 1);
        check("ovl_bit7_ol0", int'(dout0), 0);

        // Near misses.
        step(1'b1, 1'b0);
        miss_a = 5'b10011;
        for (int i = 4; i >= 0; i--) begin
            step(1'b0, miss_a[i]);
            check("miss_10011", int'(dout1 | dout0), 0);
        end
        step(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1);
            check("miss_1111", int'(dout1 | dout0), 0);
        end

        // Reset mid-pattern.
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        check("rst_mid_nohit", int'(dout1 | dout0), 0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check("rst_mid_hit_ol1", int'(dout1), 1);
        check("rst_mid_hit_ol0", int'(dout0), 1);

`ifdef FSM4_MATCH_CNT_EN
        // Three separate patterns, then saturation, then reset clear.
        step(1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            bits4(4'b1011);
            step(1'b0, 1'b0);
            step(1'b0, 1'b0);
        end
        check("cnt_three_ol1", int'(cnt1), 3);
        check("cnt_three_ol0", int'(cnt0), 3);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        for (int k = 0; k < 300; k++) begin
            step(1'b0, 1'b0);
            step(1'b0, 1'b1);
            step(1'b0, 1'b1);
        end
        check("cnt_sat_ol1", int'(cnt1), 255);
        step(1'b1, 1'b1);
        check("cnt_rst_ol1", int'(cnt1), 0);
        check("cnt_rst_ol0", int'(cnt0), 0);
`endif

        // Randomised stream, biased toward ones, with occasional resets.
        step(1'b1, 1'b0);
        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0);
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
